// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the write port of a single
// synch_fifo among NUM_REQ valid/ready requesters. A winner owns the port for
// a burst of up to BURST_MAX beats, and is only granted when the FIFO has room
// for a full burst.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_PTR   = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                          fifo_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic [FIFO_PTR:0]             fifo_room_avail,
  output logic                          fifo_wren,
  output logic [FIFO_WIDTH-1:0]         fifo_wrdata,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  localparam int              CNT_W       = $clog2(BURST_MAX + 1);
  localparam logic [FIFO_PTR:0] ROOM_NEED = (FIFO_PTR + 1)'(BURST_MAX);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_MAX - 1);
  localparam logic [ID_W-1:0]  LAST_ID_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       last_id, last_id_nxt;
  logic [ID_W-1:0]       grant_id_nxt;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
  logic [FIFO_WIDTH-1:0] req_word [NUM_REQ];
  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       cand;
  logic                  beat;

  // Unpack the flat data bus so the owner's word can be picked by index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Round-robin search starting just after the last released requester,
  // so the previous owner is always considered last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // State register; reset drops any grant and restarts priority at requester 0.
  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_id  <= LAST_ID_RST;
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      last_id  <= last_id_nxt;
      beat_cnt <= beat_cnt_nxt;
      grant_id <= grant_id_nxt;
    end
  end

  // Next-state and output decode: arbitrate in IDLE, stream beats in GRANT,
  // stall on full and release on burst limit or when the owner drops valid.
  always_comb begin
    state_nxt    = state;
    last_id_nxt  = last_id;
    beat_cnt_nxt = beat_cnt;
    grant_id_nxt = grant_id;
    req_ready    = '0;
    fifo_wren    = 1'b0;
    fifo_wrdata  = '0;
    grant_valid  = 1'b0;
    beat         = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found && (fifo_room_avail >= ROOM_NEED)) begin
          state_nxt    = GRANT;
          grant_id_nxt = win_id;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        grant_valid         = 1'b1;
        req_ready[grant_id] = ~fifo_full;
        beat                = req_valid[grant_id] & ~fifo_full;
        fifo_wren           = beat;
        fifo_wrdata         = beat ? req_word[grant_id] : '0;
        if (!fifo_full) begin
          if (!req_valid[grant_id]) begin
            state_nxt    = IDLE;
            last_id_nxt  = grant_id;
            beat_cnt_nxt = '0;
          end else if (beat_cnt == LAST_BEAT) begin
            state_nxt    = IDLE;
            last_id_nxt  = grant_id;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a random
// run against a behavioural arbiter/FIFO model.
module tb_fifo_wr_arbiter;

  logic         fifo_clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         fifo_full;
  logic [4:0]   fifo_room_avail;
  logic         fifo_wren;
  logic [31:0]  fifo_wrdata;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int n_cmp;
  int n_bad;
  int seqm [4];

  fifo_wr_arbiter #(
    .NUM_REQ(4), .ID_W(2), .FIFO_WIDTH(32), .FIFO_PTR(4), .BURST_MAX(4)
  ) dut (
    .fifo_clk       (fifo_clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fifo_full      (fifo_full),
    .fifo_room_avail(fifo_room_avail),
    .fifo_wren      (fifo_wren),
    .fifo_wrdata    (fifo_wrdata),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  // Tagged data word: requester id and a per-requester sequence number.
  function automatic logic [31:0] word(input int i, input int s);
    return 32'hA000_0000 | (32'(i) << 16) | (32'(s) & 32'h0000_FFFF);
  endfunction

  // Observation vector; grant_id only meaningful while a grant is held.
  function automatic logic [39:0] obs();
    return {grant_valid, (grant_valid ? grant_id : 2'd0), req_ready, fifo_wren, fifo_wrdata};
  endfunction

  task automatic tick();
    @(posedge fifo_clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = word(i, seqm[i]);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    req_valid       = 4'b0;
    req_data        = '0;
    fifo_full       = 1'b0;
    fifo_room_avail = 5'd16;
    for (int i = 0; i < 4; i++) seqm[i] = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] got;
    rst = 1'b1;
    req_valid = 4'b1111;
    fifo_room_avail = 5'd16;
    look();
    got = {grant_valid, grant_id, req_ready, fifo_wren, fifo_wrdata};
    n_cmp++;
    if (got !== 40'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %h want %h", got, 40'h0);
    end
    tick();
    tick();
    look();
    got = {grant_valid, grant_id, req_ready, fifo_wren, fifo_wrdata};
    n_cmp++;
    if (got !== 40'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_ignores_clock: got %h want %h", got, 40'h0);
    end
    tick();
  endtask

  task automatic test_single();
    logic [31:0] vals [3];
    logic [39:0] exp_v;
    vals = '{32'h11, 32'h22, 32'h33};
    do_reset();
    req_valid = 4'b0001;
    req_data[31:0] = vals[0];
    look();
    n_cmp++;
    if (obs() !== 40'h0) begin
      n_bad++;
      $display("[TB] FAIL single_arb_cycle: got %h want %h", obs(), 40'h0);
    end
    tick();
    for (int b = 0; b < 3; b++) begin
      req_data[31:0] = vals[b];
      look();
      exp_v = {1'b1, 2'd0, 4'b0001, 1'b1, vals[b]};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL single_beat%0d: got %h want %h", b, obs(), exp_v);
      end
      tick();
    end
    req_valid = 4'b0;
    look();
    exp_v = {1'b1, 2'd0, 4'b0001, 1'b0, 32'h0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL single_end: got %h want %h", obs(), exp_v);
    end
    tick();
    look();
    n_cmp++;
    if (obs() !== 40'h0) begin
      n_bad++;
      $display("[TB] FAIL single_idle_after: got %h want %h", obs(), 40'h0);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [39:0] exp_v;
    int g;
    do_reset();
    req_valid = 4'b1111;
    set_data();
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      look();
      n_cmp++;
      if (obs() !== 40'h0) begin
        n_bad++;
        $display("[TB] FAIL rr_gap%0d: got %h want %h", n, obs(), 40'h0);
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        set_data();
        look();
        exp_v = {1'b1, 2'(g), 4'(1 << g), 1'b1, word(g, seqm[g])};
        n_cmp++;
        if (obs() !== exp_v) begin
          n_bad++;
          $display("[TB] FAIL rr_grant%0d_beat%0d: got %h want %h", n, b, obs(), exp_v);
        end
        tick();
        seqm[g]++;
      end
    end
    req_valid = 4'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [39:0] exp_v;
    do_reset();
    req_valid = 4'b0100;
    set_data();
    look();
    tick();
    for (int c = 0; c < 7; c++) begin
      fifo_full = (c >= 2 && c < 5);
      set_data();
      look();
      if (fifo_full) exp_v = {1'b1, 2'd2, 4'b0000, 1'b0, 32'h0};
      else           exp_v = {1'b1, 2'd2, 4'b0100, 1'b1, word(2, seqm[2])};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL stall_cycle%0d: got %h want %h", c, obs(), exp_v);
      end
      tick();
      if (!fifo_full) seqm[2]++;
    end
    fifo_full = 1'b0;
    look();
    n_cmp++;
    if (obs() !== 40'h0) begin
      n_bad++;
      $display("[TB] FAIL stall_release: got %h want %h", obs(), 40'h0);
    end
    req_valid = 4'b0;
    tick();
  endtask

  task automatic test_room_gate();
    logic [39:0] exp_v;
    do_reset();
    req_valid = 4'b0010;
    set_data();
    look();
    tick();
    look();
    tick();
    req_valid = 4'b0;
    look();
    tick();
    req_valid = 4'b1111;
    fifo_room_avail = 5'd3;
    set_data();
    for (int c = 0; c < 3; c++) begin
      look();
      n_cmp++;
      if (obs() !== 40'h0) begin
        n_bad++;
        $display("[TB] FAIL room_low%0d: got %h want %h", c, obs(), 40'h0);
      end
      tick();
    end
    fifo_room_avail = 5'd4;
    look();
    tick();
    look();
    exp_v = {1'b1, 2'd2, 4'b0100, 1'b1, word(2, 0)};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL room_grant_next: got %h want %h", obs(), exp_v);
    end
    req_valid = 4'b0;
    fifo_room_avail = 5'd16;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [39:0] got;
    logic [39:0] exp_v;
    do_reset();
    req_valid = 4'b0010;
    set_data();
    look();
    tick();
    look();
    tick();
    look();
    rst = 1'b1;
    #1;
    got = {grant_valid, grant_id, req_ready, fifo_wren, fifo_wrdata};
    n_cmp++;
    if (got !== 40'h0) begin
      n_bad++;
      $display("[TB] FAIL midrst_outputs: got %h want %h", got, 40'h0);
    end
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    set_data();
    look();
    tick();
    look();
    exp_v = {1'b1, 2'd1, 4'b0010, 1'b1, word(1, 0)};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL midrst_regrant: got %h want %h", obs(), exp_v);
    end
    req_valid = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [39:0] exp_v;
    int owner, nxt_owner, last, beats, seqr [4];
    logic bw;
    do_reset();
    owner = -1;
    last  = 3;
    beats = 0;
    for (int i = 0; i < 4; i++) seqr[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = ($urandom_range(3) != 0);
        req_data[i*32 +: 32] = word(i, seqr[i]);
      end
      fifo_full       = (q.size() == 16);
      fifo_room_avail = 5'(16 - q.size());
      look();
      nxt_owner = owner;
      bw = 1'b0;
      if (owner < 0) begin
        exp_v = 40'h0;
        if (req_valid != 4'b0 && (16 - q.size()) >= 4) begin
          for (int k = 1; k <= 4; k++) begin
            if (nxt_owner < 0 && req_valid[(last + k) % 4]) nxt_owner = (last + k) % 4;
          end
          beats = 0;
        end
      end else begin
        bw = req_valid[owner] && !fifo_full;
        exp_v = {1'b1, 2'(owner), (fifo_full ? 4'b0 : 4'(1 << owner)), bw,
                 (bw ? word(owner, seqr[owner]) : 32'h0)};
        if (!fifo_full) begin
          if (!req_valid[owner]) begin
            last = owner;
            nxt_owner = -1;
          end else begin
            beats++;
            if (beats == 4) begin
              last = owner;
              nxt_owner = -1;
              beats = 0;
            end
          end
        end
      end
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL rand_cycle%0d: got %h want %h", c, obs(), exp_v);
      end
      if (fifo_full) begin
        n_cmp++;
        if (fifo_wren !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL rand_write_when_full%0d: got %b want 0", c, fifo_wren);
        end
      end
      if (bw) begin
        q.push_back(word(owner, seqr[owner]));
        seqr[owner]++;
      end
      if (q.size() < 16 && $urandom_range(7) == 0) q.push_back(32'hFFFF_FFFF);
      if (q.size() > 0 && $urandom_range(2) == 0) void'(q.pop_front());
      owner = nxt_owner;
      tick();
    end
    req_valid = 4'b0;
    tick();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req_valid = 4'b0;
    req_data = '0;
    fifo_full = 1'b0;
    fifo_room_avail = 5'd16;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_room_gate();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
